// File: rtl/midi_pkg.sv
// Shared constants and state encodings for the MIDI note decoder.
package midi_pkg;

    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [7:0] REALTIME_MIN    = 8'hF8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    typedef enum logic [1:0] {NONE, WAIT_D1, WAIT_D2} parse_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver for the MIDI line: 2-FF synchronizer, start-bit glitch
// rejection, centre sampling, and a frame-error pulse on a low stop bit.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 31250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic [1:0]       sync_q;
    logic             rx_prev_q;
    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             err_wait_q, err_wait_d;
    logic             rx_s;

    assign rx_s        = sync_q[1];
    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        err_wait_d = err_wait_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // After a bad stop bit, hold here until the line idles high again.
                if (err_wait_q) begin
                    if (rx_s) begin
                        err_wait_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        err_wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            err_wait_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_i};
            rx_prev_q  <= rx_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            err_wait_q <= err_wait_d;
        end
    end

endmodule

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI Note On/Off decoder with running status.
// Optional build macro MIDI_CHANNEL_FILTER_EN restricts note messages to CHANNEL.
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 31250,
    parameter int CHANNEL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_rx,
    output logic [6:0] MIDI_freq,
    output logic [6:0] volume,
    output logic       gate,
    output logic       note_on,
    output logic       note_off,
    output logic       frame_err
);

`ifdef MIDI_CHANNEL_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam logic [3:0] CHAN_NIB = 4'(CHANNEL);

    logic [7:0]   rx_byte;
    logic         rx_valid;

    parse_state_t pstate_q, pstate_d;
    logic         is_on_q, is_on_d;
    logic [6:0]   d1_q, d1_d;
    logic [6:0]   freq_q, freq_d;
    logic [6:0]   vol_q, vol_d;
    logic         gate_q, gate_d;
    logic         on_q, on_d;
    logic         off_q, off_d;
    logic         chan_ok;

    midi_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (midi_rx),
        .data_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (frame_err)
    );

    assign chan_ok   = !FILTER_EN || (rx_byte[3:0] == CHAN_NIB);
    assign MIDI_freq = freq_q;
    assign volume    = vol_q;
    assign gate      = gate_q;
    assign note_on   = on_q;
    assign note_off  = off_q;

    always_comb begin
        pstate_d = pstate_q;
        is_on_d  = is_on_q;
        d1_d     = d1_q;
        freq_d   = freq_q;
        vol_d    = vol_q;
        gate_d   = gate_q;
        on_d     = 1'b0;
        off_d    = 1'b0;
        if (rx_valid && rx_byte < REALTIME_MIN) begin
            if (rx_byte[7]) begin
                if (rx_byte[7:4] == STATUS_NOTE_ON && chan_ok) begin
                    is_on_d  = 1'b1;
                    pstate_d = WAIT_D1;
                end else if (rx_byte[7:4] == STATUS_NOTE_OFF && chan_ok) begin
                    is_on_d  = 1'b0;
                    pstate_d = WAIT_D1;
                end else begin
                    pstate_d = NONE;
                end
            end else begin
                case (pstate_q)
                    WAIT_D1: begin
                        d1_d     = rx_byte[6:0];
                        pstate_d = WAIT_D2;
                    end
                    WAIT_D2: begin
                        pstate_d = WAIT_D1;
                        // Velocity 0 on a Note On is a Note Off by MIDI convention.
                        if (is_on_q && rx_byte[6:0] != 7'd0) begin
                            freq_d = d1_q;
                            vol_d  = rx_byte[6:0];
                            gate_d = 1'b1;
                            on_d   = 1'b1;
                        end else if (gate_q && d1_q == freq_q) begin
                            gate_d = 1'b0;
                            vol_d  = 7'd0;
                            off_d  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q <= NONE;
            is_on_q  <= 1'b0;
            d1_q     <= 7'd0;
            freq_q   <= 7'd0;
            vol_q    <= 7'd0;
            gate_q   <= 1'b0;
            on_q     <= 1'b0;
            off_q    <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            is_on_q  <= is_on_d;
            d1_q     <= d1_d;
            freq_q   <= freq_d;
            vol_q    <= vol_d;
            gate_q   <= gate_d;
            on_q     <= on_d;
            off_q    <= off_d;
        end
    end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: directed test-plan steps then random byte
// streams, all compared against a queue-based message model.
module tb_midi_note_decoder;

    localparam int CLK_FREQ = 500000;
    localparam int BAUD     = 31250;
    localparam int BIT      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       midi_rx = 1'b1;
    logic [6:0] MIDI_freq;
    logic [6:0] volume;
    logic       gate;
    logic       note_on;
    logic       note_off;
    logic       frame_err;

    midi_note_decoder #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .CHANNEL  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .midi_rx   (midi_rx),
        .MIDI_freq (MIDI_freq),
        .volume    (volume),
        .gate      (gate),
        .note_on   (note_on),
        .note_off  (note_off),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int on_seen = 0, off_seen = 0, ferr_seen = 0;
    int last_on_cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (note_on)   begin on_seen++; last_on_cyc = cyc; end
        if (note_off)  off_seen++;
        if (frame_err) ferr_seen++;
    end

    // Reference model: message-level view of the byte stream.
    int   m_status = -1;
    int   m_pending[$];
    int   m_freq = 0, m_vol = 0, m_gate = 0;
    int   exp_on = 0, exp_off = 0, exp_ferr = 0;

    function automatic bit model_chan_ok(input int b);
`ifdef MIDI_CHANNEL_FILTER_EN
        return (b % 16) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_byte(input int b);
        int note, vel;
        if (b >= 248) return;
        if (b >= 128) begin
            m_pending.delete();
            if ((b / 16 == 9 || b / 16 == 8) && model_chan_ok(b)) m_status = b;
            else m_status = -1;
            return;
        end
        if (m_status < 0) return;
        m_pending.push_back(b);
        if (m_pending.size() == 2) begin
            note = m_pending[0];
            vel  = m_pending[1];
            m_pending.delete();
            if (m_status / 16 == 9 && vel != 0) begin
                m_freq = note; m_vol = vel; m_gate = 1; exp_on++;
            end else if (m_gate == 1 && note == m_freq) begin
                m_gate = 0; m_vol = 0; exp_off++;
            end
        end
    endtask

    task automatic model_reset();
        m_status = -1;
        m_pending.delete();
        m_freq = 0; m_vol = 0; m_gate = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".freq"},  int'(MIDI_freq), m_freq);
        check({tag, ".vol"},   int'(volume),    m_vol);
        check({tag, ".gate"},  int'(gate),      m_gate);
        check({tag, ".on#"},   on_seen,         exp_on);
        check({tag, ".off#"},  off_seen,        exp_off);
        check({tag, ".ferr#"}, ferr_seen,       exp_ferr);
        $display("txn %s: freq=%0d vol=%0d gate=%0d on#=%0d off#=%0d ferr#=%0d",
                 tag, MIDI_freq, volume, gate, on_seen, off_seen, ferr_seen);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        start_cyc = cyc;
        midi_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            wait_cyc(BIT);
        end
        midi_rx = stop_bit;
        wait_cyc(BIT);
        midi_rx = 1'b1;
        wait_cyc(2 * BIT);
        if (stop_bit) model_byte(int'(b));
        else exp_ferr++;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        model_reset();
        wait_cyc(2);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);
        check("reset.on_pulse", int'(note_on), 0);
        check_all("reset");

        // Note On with latency window around the stop-bit centre.
        send(8'h90); send(8'h3C); send(8'h64);
        lat = last_on_cyc - start_cyc;
        check("note_on.latency_ok", int'(lat >= 9 * BIT + BIT / 2 && lat <= 9 * BIT + BIT / 2 + 8), 1);
        check("note_on.freq60", int'(MIDI_freq), 60);
        check_all("note_on");

        send(8'h40); send(8'h50);
        check("running.freq64", int'(MIDI_freq), 64);
        check_all("running");

        send(8'h80); send(8'h3C); send(8'h00);
        check_all("off_other_note");

        send(8'h90); send(8'h40); send(8'h00);
        check("vel0_off.gate", int'(gate), 0);
        check_all("vel0_off");

        send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h7F);
        check("realtime.vol127", int'(volume), 127);
        check_all("realtime");

        // Short low glitch must not produce a byte.
        @(posedge clk); #1;
        midi_rx = 1'b0;
        wait_cyc(BIT / 4);
        midi_rx = 1'b1;
        wait_cyc(3 * BIT);
        check_all("glitch");

        send_frame(8'h3C, 1'b0);
        check_all("frame_err");

        send(8'h90); send(8'h3C);
        do_reset();
        check_all("reset_mid_msg");
        send(8'h3C); send(8'h64);
        check_all("bare_data_after_reset");

        send(8'h91); send(8'h3C); send(8'h64);
        check_all("chan1");
        send(8'h80); send(8'h3C); send(8'h00);
        send(8'h90); send(8'h3C); send(8'h64);
        check_all("chan0");

        // Random byte streams biased toward note messages on a few notes.
        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 9))
                0: b = 8'h90;
                1: b = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h91;
                2: b = ($urandom_range(0, 1) != 0) ? 8'hF8 : 8'hB0;
                3: b = 8'h00;
                default: b = 8'(($urandom_range(0, 1) != 0) ? $urandom_range(60, 62) : $urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 15) == 0) send_frame(b, 1'b0);
            else send(b);
            check_all($sformatf("rand%0d_b%02h", i, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
